// File: rtl/cpu_control_if.sv
// Memory-side bus of the instruction sequencer.
//   instr     : data bus as seen by the sequencer (instruction word on fetch)
//   mem_valid : memory completed the current request
//   mem_req   : memory access request
//   mem_we    : write qualifier for mem_req
// The master modport is the sequencer; the slave modport is the memory side.
interface cpu_control_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] instr;
  logic             mem_valid;
  logic             mem_req;
  logic             mem_we;

  modport master (
    input  instr,
    input  mem_valid,
    output mem_req,
    output mem_we
  );

  modport slave (
    output instr,
    output mem_valid,
    input  mem_req,
    input  mem_we
  );
endinterface

// File: rtl/cpu_control.sv
// Instruction sequencer and decoder placed in front of the processor datapath.
// Fetches an instruction word, splits it into opcode/oppA/oppB/literal and steps a
// Moore FSM (FETCH, DECODE, EXEC, MEM, NEXT, HALT) that drives the datapath strobes.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   bus         : memory bus (instr, mem_valid in; mem_req, mem_we out)
//   opcode      : IR[31:26]
//   oppA, oppB  : IR[25:21], IR[20:16]
//   literal     : IR[15:0] sign-extended to WIDTH
//   regEn       : register-file write strobe
//   DataCon     : datapath drives the data bus
//   AddCon      : address bus from ALU result (else from PC)
//   increment   : one-cycle PC advance pulse
//   halted      : sequencer stopped in HALT
//   error       : memory wait timed out
//
// Optional feature: define CPU_CTRL_TIMEOUT_EN to add an 8-bit wait counter that
// halts the sequencer with error=1 after TIMEOUT cycles without mem_valid.
module cpu_control #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  cpu_control_if.master    bus,
  output logic [5:0]       opcode,
  output logic [4:0]       oppA,
  output logic [4:0]       oppB,
  output logic [WIDTH-1:0] literal,
  output logic             regEn,
  output logic             DataCon,
  output logic             AddCon,
  output logic             increment,
  output logic             halted,
  output logic             error
);

  localparam logic [5:0] OpHalt = 6'b100001;

  if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255 to fit the 8-bit wait counter");
  end

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StNext,
    StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             mem_req, mem_we;
  logic             is_store;

  assign opcode   = ir_q[31:26];
  assign oppA     = ir_q[25:21];
  assign oppB     = ir_q[20:16];
  assign literal  = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign is_store = ir_q[26];

`ifdef CPU_CTRL_TIMEOUT_EN
  localparam logic [8:0] TimeoutCnt = 9'(TIMEOUT);
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      StFetch: begin
        if (bus.mem_valid) begin
          ir_d    = bus.instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        unique case (opcode[5:4])
          2'b00, 2'b11: state_d = StExec;
          2'b01:        state_d = StMem;
          2'b10:        state_d = (opcode == OpHalt) ? StHalt : StNext;
        endcase
      end
      StExec:  state_d = StNext;
      StMem:   if (bus.mem_valid) state_d = StNext;
      StNext:  state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase

`ifdef CPU_CTRL_TIMEOUT_EN
    wait_d = wait_q;
    err_d  = err_q;
    if ((state_q == StFetch || state_q == StMem) && !bus.mem_valid) begin
      if (wait_q != 8'hFF) wait_d = wait_q + 8'd1;
      // Trip on the cycle whose wait would bring the count up to TIMEOUT.
      if ({1'b0, wait_q} + 9'd1 >= TimeoutCnt) begin
        state_d = StHalt;
        err_d   = 1'b1;
      end
    end
    // Any state change (including entry to FETCH/MEM) restarts the count.
    if (state_d != state_q) wait_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

`ifdef CPU_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  // Moore outputs; gated by reset so every strobe drops in the same cycle reset rises,
  // even though the state register already reads FETCH.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    regEn     = 1'b0;
    DataCon   = 1'b0;
    AddCon    = 1'b0;
    increment = 1'b0;
    halted    = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StFetch: mem_req = 1'b1;
        StExec: begin
          DataCon = 1'b1;
          regEn   = 1'b1;
        end
        StMem: begin
          mem_req = 1'b1;
          AddCon  = 1'b1;
          if (is_store) begin
            mem_we  = 1'b1;
            DataCon = 1'b1;
          end else begin
            regEn = bus.mem_valid;
          end
        end
        StNext:  increment = 1'b1;
        StHalt:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.mem_req = mem_req;
  assign bus.mem_we  = mem_we;

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: table of instruction records with expected
// per-instruction behaviour, queued at issue and compared when increment marks
// completion, plus hand-written HALT, reset-in-EXEC and timeout sequences.
module tb_cpu_control;

  localparam int unsigned Width = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic [4:0]       oppA, oppB;
  logic [Width-1:0] literal;
  logic             regEn, DataCon, AddCon, increment, halted, error;

  always #5 clk = ~clk;

  cpu_control_if #(.WIDTH(Width)) bus ();

  cpu_control #(.WIDTH(Width), .TIMEOUT(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .opcode    (opcode),
    .oppA      (oppA),
    .oppB      (oppB),
    .literal   (literal),
    .regEn     (regEn),
    .DataCon   (DataCon),
    .AddCon    (AddCon),
    .increment (increment),
    .halted    (halted),
    .error     (error)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          fetch_wait;
    int          mem_wait;
    int          cycles;     // total cycles FETCH..NEXT
    int          regen_cnt;
    int          regen_cyc;  // cycle index of the regEn pulse, 0 if none
    logic        regen_dc;   // DataCon during regEn
    logic        regen_ac;   // AddCon during regEn
    logic        saw_we;
    logic        saw_ac;
    logic        mem_dc;     // DataCon while AddCon
    logic [5:0]  opc;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] lit;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drives one instruction and acts as the memory responder until increment is seen.
  task automatic run_instr(input vec_t v);
    vec_t e;
    int   cyc = 0, fw = 0, mw = 0, rcnt = 0, rcyc = 0;
    logic rdc = 0, rac = 0, swe = 0, sac = 0, mdc = 0, we_bad = 0, done = 0;
    sb.push_back(v);
    bus.instr = v.instr;
    check({v.name, "/mem_req_first"}, 32'(bus.mem_req), 32'd1);
    while (!done && cyc < 60) begin
      cyc++;
      if (bus.mem_req && !AddCon) begin
        bus.mem_valid = (fw >= v.fetch_wait);
        fw++;
      end else if (bus.mem_req) begin
        bus.mem_valid = (mw >= v.mem_wait);
        mw++;
      end else begin
        bus.mem_valid = 1'($urandom_range(1));
      end
      #1;
      if (bus.mem_we && !bus.mem_req) we_bad = 1'b1;
      if (regEn) begin
        rcnt++;
        rcyc = cyc;
        rdc  = DataCon;
        rac  = AddCon;
      end
      if (bus.mem_we) swe = 1'b1;
      if (AddCon) sac = 1'b1;
      if (AddCon && DataCon) mdc = 1'b1;
      if (increment) done = 1'b1;
      @(negedge clk);
      #1;
    end
    check({v.name, "/completed"}, 32'(done), 32'd1);
    e = sb.pop_front();
    check({e.name, "/cycles"}, 32'(cyc), 32'(e.cycles));
    check({e.name, "/regen_cnt"}, 32'(rcnt), 32'(e.regen_cnt));
    check({e.name, "/regen_cyc"}, 32'(rcyc), 32'(e.regen_cyc));
    check({e.name, "/regen_datacon"}, 32'(rdc), 32'(e.regen_dc));
    check({e.name, "/regen_addcon"}, 32'(rac), 32'(e.regen_ac));
    check({e.name, "/mem_we_seen"}, 32'(swe), 32'(e.saw_we));
    check({e.name, "/addcon_seen"}, 32'(sac), 32'(e.saw_ac));
    check({e.name, "/mem_datacon"}, 32'(mdc), 32'(e.mem_dc));
    check({e.name, "/we_without_req"}, 32'(we_bad), 32'd0);
    check({e.name, "/opcode"}, 32'(opcode), 32'(e.opc));
    check({e.name, "/oppA"}, 32'(oppA), 32'(e.a));
    check({e.name, "/oppB"}, 32'(oppB), 32'(e.b));
    check({e.name, "/literal"}, literal, e.lit);
    check({e.name, "/error"}, 32'(error), 32'd0);
  endtask

  int   cyc;
  logic inc_seen, req_seen, unhalt;

  initial begin
    // name, instr, fw, mw, cycles, rcnt, rcyc, rdc, rac, we, ac, mdc, opc, a, b, lit
    vecs[0] = '{"alu_rr", 32'h00221000, 0, 0, 4, 1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                6'h00, 5'd1, 5'd2, 32'h00001000};
    vecs[1] = '{"alu_lit", 32'hC4430005, 2, 0, 6, 1, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                6'h31, 5'd2, 5'd3, 32'h00000005};
    vecs[2] = '{"load", 32'h4822FFFC, 0, 3, 7, 1, 6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                6'h12, 5'd1, 5'd2, 32'hFFFFFFFC};
    vecs[3] = '{"store", 32'h44220008, 0, 0, 4, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                6'h11, 5'd1, 5'd2, 32'h00000008};
    // Opcode 010011 has bit 26 set, so this word decodes as a store.
    vecs[4] = '{"store_wait", 32'h4C22FFFC, 1, 3, 8, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                6'h13, 5'd1, 5'd2, 32'hFFFFFFFC};
    vecs[5] = '{"nop", 32'h9C000001, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                6'h27, 5'd0, 5'd0, 32'h00000001};

    reset         = 1'b1;
    bus.instr     = '0;
    bus.mem_valid = 1'b0;
    #1;
    check("reset/strobes", 32'({bus.mem_req, bus.mem_we, regEn, DataCon, AddCon, increment,
                                halted, error}), 32'd0);
    check("reset/fields", 32'({opcode, oppA, oppB}), 32'd0);
    check("reset/literal", literal, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;

    for (int i = 0; i < 6; i++) run_instr(vecs[i]);

    // HALT: FETCH, DECODE, then halted with no further memory traffic.
    bus.instr = 32'h84000000;
    cyc       = 0;
    inc_seen  = 1'b0;
    while (!halted && cyc < 20) begin
      bus.mem_valid = bus.mem_req ? 1'b1 : 1'($urandom_range(1));
      #1;
      if (increment) inc_seen = 1'b1;
      if (!halted) begin
        cyc++;
        @(negedge clk);
        #1;
      end
    end
    check("halt/entry_cycles", 32'(cyc), 32'd2);
    check("halt/opcode", 32'(opcode), 32'h21);
    req_seen = 1'b0;
    unhalt   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.mem_valid = 1'($urandom_range(1));
      #1;
      if (bus.mem_req) req_seen = 1'b1;
      if (increment) inc_seen = 1'b1;
      if (!halted) unhalt = 1'b1;
      @(negedge clk);
      #1;
    end
    check("halt/mem_req", 32'(req_seen), 32'd0);
    check("halt/increment", 32'(inc_seen), 32'd0);
    check("halt/stays_halted", 32'(unhalt), 32'd0);
    check("halt/error", 32'(error), 32'd0);

    // Reset asserted during EXEC.
    reset = 1'b1;
    @(negedge clk);
    reset         = 1'b0;
    bus.instr     = 32'h00221000;
    bus.mem_valid = 1'b1;
    #1;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    check("rst_exec/in_exec", 32'({regEn, DataCon}), 32'b11);
    reset = 1'b1;
    #1;
    check("rst_exec/strobes", 32'({bus.mem_req, bus.mem_we, regEn, DataCon, AddCon, increment,
                                   halted}), 32'd0);
    check("rst_exec/fields", 32'({opcode, oppA, oppB}), 32'd0);
    @(negedge clk);
    #1;
    check("rst_exec/no_increment", 32'(increment), 32'd0);
    reset = 1'b0;
    #1;
    run_instr(vecs[0]);

`ifdef CPU_CTRL_TIMEOUT_EN
    // Memory never answers the fetch: halt with error after TIMEOUT (10) cycles.
    reset = 1'b1;
    @(negedge clk);
    reset         = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    cyc = 0;
    while (!halted && cyc < 30) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check("timeout/cycles", 32'(cyc), 32'd10);
    check("timeout/error", 32'(error), 32'd1);
    check("timeout/halted", 32'(halted), 32'd1);
    check("timeout/mem_req", 32'(bus.mem_req), 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion",
             checks);
    $fatal(1);
  end

endmodule
